// File: rtl/alu_cmd_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_ctrl_if
// Bundles the three buses around the ALU command controller: the UART RX byte
// stream, the ALU operand/function/result bus and the UART TX byte handshake.
//
//   RX_P_DATA / RX_D_VLD      received byte and its one-cycle strobe
//   ALU_A / ALU_B / ALU_FUN   operands and function code to the ALU
//   ALU_EN / CLK_GATE_EN      one-cycle ALU enable, ALU clock-gate enable
//   ALU_OUT / ALU_OUT_VALID   registered ALU result and its qualifier
//   TX_P_DATA / TX_D_VLD      byte to transmit and its request
//   TX_BUSY                   TX serializer busy
//   CTRL_BUSY                 controller is not idle
//
// master: the controller side.  slave: the UART/ALU environment side.
// ----------------------------------------------------------------------------
interface alu_cmd_ctrl_if #(
    parameter int OPER_WIDTH = 8,
    parameter int OUT_WIDTH  = 8
);
    logic [7:0]            RX_P_DATA;
    logic                  RX_D_VLD;
    logic [OPER_WIDTH-1:0] ALU_A;
    logic [OPER_WIDTH-1:0] ALU_B;
    logic [3:0]            ALU_FUN;
    logic                  ALU_EN;
    logic                  CLK_GATE_EN;
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VALID;
    logic [7:0]            TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  TX_BUSY;
    logic                  CTRL_BUSY;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, CTRL_BUSY
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, CTRL_BUSY
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// alu_cmd_ctrl
// Command-side initiator for the system ALU. Parses CMD_OPER (A, B, FUN) and
// CMD_NOOPER (FUN only) frames from the RX byte stream, opens the ALU clock
// gate one cycle ahead of a one-cycle ALU enable, captures the result (or an
// error byte on timeout) and sends it byte-wise over the TX handshake.
//
//   CLK   system clock
//   RST   asynchronous, active-low reset
//   bus   alu_cmd_ctrl_if.master: RX input, ALU bus, TX handshake, CTRL_BUSY
//
// Every output is registered except CTRL_BUSY, decoded from the state.
// ----------------------------------------------------------------------------
module alu_cmd_ctrl #(
    parameter int         OPER_WIDTH  = 8,
    parameter int         OUT_WIDTH   = 8,
    parameter logic [7:0] CMD_OPER    = 8'hCC,
    parameter logic [7:0] CMD_NOOPER  = 8'hDD,
    parameter int         RES_TIMEOUT = 8,
    parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
    input  logic           CLK,
    input  logic           RST,
    alu_cmd_ctrl_if.master bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_GET_A    = 4'd1;
    localparam logic [3:0] S_GET_B    = 4'd2;
    localparam logic [3:0] S_GET_FUN  = 4'd3;
    localparam logic [3:0] S_GATE_ON  = 4'd4;
    localparam logic [3:0] S_EXEC     = 4'd5;
    localparam logic [3:0] S_WAIT_RES = 4'd6;
    localparam logic [3:0] S_SEND_LO  = 4'd7;
    localparam logic [3:0] S_SEND_HI  = 4'd8;

    localparam int               CNT_W    = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_TIMEOUT - 1);

    logic [3:0]            r_state;
    logic [OPER_WIDTH-1:0] r_alu_a;
    logic [OPER_WIDTH-1:0] r_alu_b;
    logic [3:0]            r_alu_fun;
    logic                  r_alu_en;
    logic                  r_clk_gate_en;
    logic [OUT_WIDTH-1:0]  r_result;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_tmo_cnt;
    logic [7:0]            r_tx_data;
    logic                  r_tx_vld;
    logic [15:0]           w_result16;

    // Zero-extended view so the high-byte select is legal for OUT_WIDTH=8.
    assign w_result16 = 16'(r_result);

    // The stored operands double as the ALU operand outputs: they only change
    // while a frame is being collected, so they are stable from GATE_ON until
    // the result is captured.
    assign bus.ALU_A       = r_alu_a;
    assign bus.ALU_B       = r_alu_b;
    assign bus.ALU_FUN     = r_alu_fun;
    assign bus.ALU_EN      = r_alu_en;
    assign bus.CLK_GATE_EN = r_clk_gate_en;
    assign bus.TX_P_DATA   = r_tx_data;
    assign bus.TX_D_VLD    = r_tx_vld;
    assign bus.CTRL_BUSY   = (r_state != S_IDLE);

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every register sees the pre-edge value of the others.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= S_IDLE;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_fun     <= '0;
            r_alu_en      <= 1'b0;
            r_clk_gate_en <= 1'b0;
            r_result      <= '0;
            r_timeout     <= 1'b0;
            r_tmo_cnt     <= '0;
            r_tx_data     <= '0;
            r_tx_vld      <= 1'b0;
        end else begin
            r_alu_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.RX_D_VLD) begin
                        if (bus.RX_P_DATA == CMD_OPER) begin
                            r_state <= S_GET_A;
                        end else if (bus.RX_P_DATA == CMD_NOOPER) begin
                            r_state <= S_GET_FUN;
                        end
                    end
                end
                S_GET_A: begin
                    if (bus.RX_D_VLD) begin
                        r_alu_a <= OPER_WIDTH'(bus.RX_P_DATA);
                        r_state <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (bus.RX_D_VLD) begin
                        r_alu_b <= OPER_WIDTH'(bus.RX_P_DATA);
                        r_state <= S_GET_FUN;
                    end
                end
                S_GET_FUN: begin
                    if (bus.RX_D_VLD) begin
                        r_alu_fun     <= bus.RX_P_DATA[3:0];
                        r_clk_gate_en <= 1'b1;
                        r_state       <= S_GATE_ON;
                    end
                end
                S_GATE_ON: begin
                    r_alu_en <= 1'b1;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_tmo_cnt <= '0;
                    r_timeout <= 1'b0;
                    r_state   <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (bus.ALU_OUT_VALID) begin
                        r_result      <= bus.ALU_OUT;
                        r_clk_gate_en <= 1'b0;
                        r_state       <= S_SEND_LO;
                    end else if (r_tmo_cnt == CNT_LAST) begin
                        r_result[7:0] <= ERR_BYTE;
                        r_timeout     <= 1'b1;
                        r_clk_gate_en <= 1'b0;
                        r_state       <= S_SEND_LO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_SEND_LO, S_SEND_HI: begin
                    // Launch only into an idle serializer; busy sampled while
                    // requesting is the acceptance.
                    if (!r_tx_vld) begin
                        if (!bus.TX_BUSY) begin
                            r_tx_data <= (r_state == S_SEND_LO) ? w_result16[7:0]
                                                                : w_result16[15:8];
                            r_tx_vld  <= 1'b1;
                        end
                    end else if (bus.TX_BUSY) begin
                        r_tx_vld <= 1'b0;
                        if (r_state == S_SEND_LO && OUT_WIDTH == 16 && !r_timeout) begin
                            r_state <= S_SEND_HI;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_ctrl
// Drives two controllers (OUT_WIDTH 8 and 16) from one RX byte stream, each
// with its own ALU model and TX serializer model. Expected TX bytes come from
// a frame-level reference model: stored operands, ALU function table, and the
// error byte when the ALU never answers.
// ----------------------------------------------------------------------------
module tb_alu_cmd_ctrl;
    localparam int RES_TIMEOUT = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    alu_cmd_ctrl_if #(.OPER_WIDTH(8), .OUT_WIDTH(8))  bus8 ();
    alu_cmd_ctrl_if #(.OPER_WIDTH(8), .OUT_WIDTH(16)) bus16 ();

    alu_cmd_ctrl #(.OUT_WIDTH(8),  .RES_TIMEOUT(RES_TIMEOUT)) dut8  (.CLK(CLK), .RST(RST), .bus(bus8));
    alu_cmd_ctrl #(.OUT_WIDTH(16), .RES_TIMEOUT(RES_TIMEOUT)) dut16 (.CLK(CLK), .RST(RST), .bus(bus16));

    // Stimulus / environment state
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_vld    = 1'b0;
    logic        alu_dead  = 1'b0;
    logic        hold_busy = 1'b0;
    logic        tx_stall  = 1'b0;
    logic        tx_busy  [2] = '{1'b0, 1'b0};
    logic [15:0] alu_out  [2];
    logic        alu_vld  [2];

    // Observed DUT outputs
    logic [7:0] a_o [2], b_o [2], txd_o [2];
    logic [3:0] fun_o [2];
    logic       en_o [2], gate_o [2], txv_o [2], busy_o [2];

    assign bus8.RX_P_DATA      = rx_data;
    assign bus8.RX_D_VLD       = rx_vld;
    assign bus8.ALU_OUT        = alu_out[0][7:0];
    assign bus8.ALU_OUT_VALID  = alu_vld[0];
    assign bus8.TX_BUSY        = tx_busy[0];
    assign bus16.RX_P_DATA     = rx_data;
    assign bus16.RX_D_VLD      = rx_vld;
    assign bus16.ALU_OUT       = alu_out[1];
    assign bus16.ALU_OUT_VALID = alu_vld[1];
    assign bus16.TX_BUSY       = tx_busy[1];

    assign a_o[0] = bus8.ALU_A;         assign a_o[1] = bus16.ALU_A;
    assign b_o[0] = bus8.ALU_B;         assign b_o[1] = bus16.ALU_B;
    assign fun_o[0] = bus8.ALU_FUN;     assign fun_o[1] = bus16.ALU_FUN;
    assign en_o[0] = bus8.ALU_EN;       assign en_o[1] = bus16.ALU_EN;
    assign gate_o[0] = bus8.CLK_GATE_EN; assign gate_o[1] = bus16.CLK_GATE_EN;
    assign txd_o[0] = bus8.TX_P_DATA;   assign txd_o[1] = bus16.TX_P_DATA;
    assign txv_o[0] = bus8.TX_D_VLD;    assign txv_o[1] = bus16.TX_D_VLD;
    assign busy_o[0] = bus8.CTRL_BUSY;  assign busy_o[1] = bus16.CTRL_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ALU function table seen by the controller.
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'h0: return 16'(a) + 16'(b);
            4'h1: return 16'(a) - 16'(b);
            4'h2: return 16'(a) * 16'(b);
            4'h3: return (b == 8'h00) ? 16'h0000 : 16'(a / b);
            4'h4: return 16'(a & b);
            4'h5: return 16'(a | b);
            4'h6: return 16'(~(a & b));
            4'h7: return 16'(~(a | b));
            4'h8: return 16'(a ^ b);
            4'h9: return 16'(~(a ^ b));
            4'hA: return (a == b) ? 16'd1 : 16'd0;
            4'hB: return (a > b)  ? 16'd2 : 16'd0;
            4'hC: return (a < b)  ? 16'd3 : 16'd0;
            4'hD: return 16'(a >> 1);
            4'hE: return 16'(a) << 1;
            default: return 16'h0000;
        endcase
    endfunction

    // Registered ALU: one-cycle latency unless told to stay silent.
    always @(posedge CLK or negedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                alu_vld[i] <= 1'b0;
                alu_out[i] <= 16'h0000;
            end else begin
                alu_vld[i] <= en_o[i] && !alu_dead;
                if (en_o[i]) alu_out[i] <= alu_fn(a_o[i], b_o[i], fun_o[i]);
            end
        end
    end

    // TX serializer model: accepts a request while idle, then stays busy 1..4 cycles.
    logic [7:0] cap0 [$];
    logic [7:0] cap1 [$];
    int  busy_cnt  [2] = '{0, 0};
    int  proto_err [2] = '{0, 0};
    int  hold_vld  [2] = '{0, 0};
    logic txv_prev [2] = '{1'b0, 1'b0};

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                busy_cnt[i] = 0;
                tx_busy[i]  = 1'b0;
                txv_prev[i] = 1'b0;
            end else begin
                if (txv_o[i] && !txv_prev[i] && tx_busy[i]) proto_err[i]++;
                if (hold_busy && txv_o[i]) hold_vld[i]++;
                if (txv_o[i] && !tx_busy[i] && !tx_stall) begin
                    if (i == 0) cap0.push_back(txd_o[i]);
                    else        cap1.push_back(txd_o[i]);
                    busy_cnt[i] = $urandom_range(4, 1);
                end else if (busy_cnt[i] > 0) begin
                    busy_cnt[i]--;
                end
                tx_busy[i]  = hold_busy || (busy_cnt[i] > 0);
                txv_prev[i] = txv_o[i];
            end
        end
    end

    // ALU-side monitor: gate leads enable, enable is one cycle, operands correct.
    logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
    logic [3:0] exp_fun = 4'h0;
    int   gate_cnt [2] = '{0, 0};
    int   en_cnt   [2] = '{0, 0};
    logic gate_prev[2] = '{1'b0, 1'b0};
    logic en_prev  [2] = '{1'b0, 1'b0};

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                if (gate_o[i]) gate_cnt[i]++;
                if (en_o[i]) begin
                    en_cnt[i]++;
                    check($sformatf("gate_leads_en[%0d]", i), 32'(gate_prev[i]), 32'd1);
                    check($sformatf("en_prev_low[%0d]", i), 32'(en_prev[i]), 32'd0);
                    check($sformatf("gate_with_en[%0d]", i), 32'(gate_o[i]), 32'd1);
                    check($sformatf("alu_a[%0d]", i), 32'(a_o[i]), 32'(exp_a));
                    check($sformatf("alu_b[%0d]", i), 32'(b_o[i]), 32'(exp_b));
                    check($sformatf("alu_fun[%0d]", i), 32'(fun_o[i]), 32'(exp_fun));
                end
            end
            gate_prev[i] = gate_o[i];
            en_prev[i]   = en_o[i];
        end
    end

    // Reference model: stored operands
    logic [7:0] m_a = 8'h00, m_b = 8'h00;

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge CLK);
        rx_vld  = 1'b0;
        rx_data = 8'($urandom);
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] v;
        do v = 8'($urandom); while (v == 8'hCC || v == 8'hDD);
        return v;
    endfunction

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_alu_a[%0d]", tag, i), 32'(a_o[i]), 32'd0);
            check($sformatf("%s_alu_b[%0d]", tag, i), 32'(b_o[i]), 32'd0);
            check($sformatf("%s_alu_fun[%0d]", tag, i), 32'(fun_o[i]), 32'd0);
            check($sformatf("%s_alu_en[%0d]", tag, i), 32'(en_o[i]), 32'd0);
            check($sformatf("%s_gate[%0d]", tag, i), 32'(gate_o[i]), 32'd0);
            check($sformatf("%s_tx_data[%0d]", tag, i), 32'(txd_o[i]), 32'd0);
            check($sformatf("%s_tx_vld[%0d]", tag, i), 32'(txv_o[i]), 32'd0);
            check($sformatf("%s_busy[%0d]", tag, i), 32'(busy_o[i]), 32'd0);
        end
    endtask

    // One complete frame: optional junk, command, operands, function, then a
    // byte that arrives while the controller is busy and must be dropped.
    task automatic run_frame(input string tag, input bit oper, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] fb, input int njunk,
                             input bit dead, input int hold);
        logic [7:0]  q[$];
        logic [7:0]  e0[$];
        logic [7:0]  e1[$];
        logic [15:0] res;
        int gb[2], eb[2], hb[2];
        int cb0, cb1, cyc;

        for (int k = 0; k < njunk; k++) q.push_back(junk_byte());
        q.push_back(oper ? 8'hCC : 8'hDD);
        if (oper) begin
            q.push_back(a);
            q.push_back(b);
            m_a = a;
            m_b = b;
        end
        q.push_back(fb);
        res = alu_fn(m_a, m_b, fb[3:0]);
        if (dead) begin
            e0.push_back(8'hEE);
            e1.push_back(8'hEE);
        end else begin
            e0.push_back(res[7:0]);
            e1.push_back(res[7:0]);
            e1.push_back(res[15:8]);
        end

        @(negedge CLK);
        #1;
        exp_a     = m_a;
        exp_b     = m_b;
        exp_fun   = fb[3:0];
        alu_dead  = dead;
        hold_busy = (hold > 0);
        gb = gate_cnt;
        eb = en_cnt;
        hb = hold_vld;
        cb0 = cap0.size();
        cb1 = cap1.size();

        foreach (q[k]) begin
            if (k > 0) repeat ($urandom_range(2, 0)) @(negedge CLK);
            send_byte(q[k]);
        end
        send_byte($urandom_range(1, 0) ? 8'hCC : 8'($urandom));

        if (hold > 0) begin
            repeat (hold) @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("%s_waiting_busy[%0d]", tag, i), 32'(busy_o[i]), 32'd1);
                check($sformatf("%s_no_vld_in_hold[%0d]", tag, i), 32'(hold_vld[i] - hb[i]), 32'd0);
            end
            #1 hold_busy = 1'b0;
        end

        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while ((busy_o[0] || busy_o[1]) && cyc < 400);
        check({tag, "_idle_reached"}, 32'(busy_o[0] | busy_o[1]), 32'd0);

        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_en_pulses[%0d]", tag, i), 32'(en_cnt[i] - eb[i]), 32'd1);
            check($sformatf("%s_gate_cycles[%0d]", tag, i), 32'(gate_cnt[i] - gb[i]),
                  dead ? 32'(2 + RES_TIMEOUT) : 32'd3);
            check($sformatf("%s_gate_off[%0d]", tag, i), 32'(gate_o[i]), 32'd0);
            check($sformatf("%s_tx_vld_off[%0d]", tag, i), 32'(txv_o[i]), 32'd0);
            check($sformatf("%s_tx_protocol[%0d]", tag, i), 32'(proto_err[i]), 32'd0);
        end
        check({tag, "_nbytes8"},  32'(cap0.size() - cb0), 32'(e0.size()));
        check({tag, "_nbytes16"}, 32'(cap1.size() - cb1), 32'(e1.size()));
        foreach (e0[k]) if (cb0 + k < cap0.size())
            check($sformatf("%s_byte8[%0d]", tag, k), 32'(cap0[cb0 + k]), 32'(e0[k]));
        foreach (e1[k]) if (cb1 + k < cap1.size())
            check($sformatf("%s_byte16[%0d]", tag, k), 32'(cap1[cb1 + k]), 32'(e1[k]));
        alu_dead = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc, cb0, cb1;

        // Reset state
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RST = 1'b1;

        // Directed frames
        run_frame("oper_add", 1'b1, 8'h05, 8'h03, 8'h00, 0, 1'b0, 0);
        run_frame("nooper_mul", 1'b0, 8'h00, 8'h00, 8'h02, 0, 1'b0, 0);
        check("stored_a_kept", 32'(a_o[0]), 32'h05);
        check("stored_b_kept", 32'(b_o[1]), 32'h03);
        send_byte(8'h11);
        run_frame("junk_cmp", 1'b1, 8'h0A, 8'h0A, 8'h0A, 0, 1'b0, 0);
        run_frame("cmd_as_data", 1'b1, 8'hDD, 8'hCC, 8'hC0, 0, 1'b0, 0);
        run_frame("timeout", 1'b0, 8'h00, 8'h00, 8'h00, 0, 1'b1, 0);
        run_frame("busy_hold", 1'b1, 8'hFF, 8'hFF, 8'h02, 0, 1'b0, 20);
        run_frame("undef_fun", 1'b0, 8'h00, 8'h00, 8'h7F, 1, 1'b0, 0);

        // Reset while a byte is being requested
        @(negedge CLK);
        #1 tx_stall = 1'b1;
        exp_a   = m_a;
        exp_b   = m_b;
        exp_fun = 4'h0;
        send_byte(8'hDD);
        send_byte(8'h00);
        cyc = 0;
        while (!(txv_o[0] && txv_o[1]) && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        check("rst_reached_send", 32'(txv_o[0] & txv_o[1]), 32'd1);
        #2 RST = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(negedge CLK);
        #1;
        RST      = 1'b1;
        tx_stall = 1'b0;
        m_a = 8'h00;
        m_b = 8'h00;
        cb0 = cap0.size();
        cb1 = cap1.size();
        repeat (30) @(negedge CLK);
        check("post_rst_no_tx8",  32'(cap0.size() - cb0), 32'd0);
        check("post_rst_no_tx16", 32'(cap1.size() - cb1), 32'd0);
        check("post_rst_idle", 32'(busy_o[0] | busy_o[1]), 32'd0);
        run_frame("post_rst_zero_ops", 1'b0, 8'h00, 8'h00, 8'h05, 0, 1'b0, 0);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra, rb;
            ra = ($urandom_range(7, 0) == 0) ? 8'hCC : 8'($urandom);
            rb = ($urandom_range(7, 0) == 0) ? 8'hDD : 8'($urandom);
            run_frame($sformatf("rnd%0d", n), 1'($urandom_range(1, 0)), ra, rb, 8'($urandom),
                      $urandom_range(2, 0), ($urandom_range(7, 0) == 0),
                      ($urandom_range(5, 0) == 0) ? $urandom_range(6, 1) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command-side initiator for the system ALU.
- Parses operand/function frames arriving as bytes from the synchronized UART RX path and drives the ALU operand/function/enable inputs.
- Gates the ALU clock only around an operation (low-power) and captures the registered ALU result.
- Serializes the result byte-wise to the UART TX path, with a busy handshake.

Parameters:
- OPER_WIDTH, 8, ALU operand width; fixed at 8 (one RX byte per operand).
- OUT_WIDTH, 8, ALU result width; legal values 8 or 16 (one or two TX bytes).
- CMD_OPER, 8'hCC, command byte: ALU op with new operands A, B, then FUN.
- CMD_NOOPER, 8'hDD, command byte: ALU op reusing stored A, B; only FUN follows.
- RES_TIMEOUT, 8, cycles allowed in WAIT_RES before abort.
- ERR_BYTE, 8'hEE, byte transmitted on timeout.

Ports:
- CLK, input, 1, system clock.
- RST, input, 1, asynchronous, active-low reset.
- RX_P_DATA, input, 8, received byte.
- RX_D_VLD, input, 1, one-cycle strobe qualifying RX_P_DATA.
- ALU_A, output, OPER_WIDTH, operand A to ALU.
- ALU_B, output, OPER_WIDTH, operand B to ALU.
- ALU_FUN, output, 4, function code to ALU.
- ALU_EN, output, 1, one-cycle ALU enable.
- CLK_GATE_EN, output, 1, ALU clock-gate enable.
- ALU_OUT, input, OUT_WIDTH, registered ALU result.
- ALU_OUT_VALID, input, 1, result qualifier.
- TX_P_DATA, output, 8, byte to transmit.
- TX_D_VLD, output, 1, TX request.
- TX_BUSY, input, 1, TX serializer busy.
- CTRL_BUSY, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0. Stored A, B, FUN and the result register are 0. State = IDLE. Reset mid-frame or mid-TX aborts immediately; no partial byte is re-sent after release.
- All outputs are registered, except CTRL_BUSY, which is decoded from the state register.
- Only RX_D_VLD cycles are consumed. RX_P_DATA is ignored otherwise.
- IDLE:
  - On a byte equal to CMD_OPER, go to GET_A.
  - On a byte equal to CMD_NOOPER, go to GET_FUN.
  - Any other byte is dropped; stay in IDLE.
- GET_A: on a byte, latch A and go to GET_B.
- GET_B: on a byte, latch B and go to GET_FUN.
- GET_FUN: on a byte, latch FUN = byte[3:0] (upper nibble ignored) and go to GATE_ON.
- No inter-byte timeout while collecting a frame. A command-valued byte received mid-frame is treated as data.
- GATE_ON: CLK_GATE_EN=1 for exactly one cycle before enabling the ALU. Go to EXEC.
- EXEC:
  - CLK_GATE_EN=1, ALU_EN=1 for exactly one cycle.
  - ALU_A, ALU_B, ALU_FUN hold the latched values from the GATE_ON cycle onward, stable until the ALU result is captured.
  - Go to WAIT_RES.
- WAIT_RES:
  - CLK_GATE_EN=1, ALU_EN=0. A timeout counter starts at 0 on entry and increments each cycle.
  - ALU_OUT_VALID=1: capture ALU_OUT into the result register, drop CLK_GATE_EN the next cycle, go to SEND_LO.
  - Counter reaches RES_TIMEOUT-1 without valid: load result low byte = ERR_BYTE, force single-byte send, go to SEND_LO.
  - Nominal ALU latency is 1 cycle: valid arrives in the first WAIT_RES cycle.
- SEND_LO / SEND_HI handshake:
  - Wait until TX_BUSY=0, then drive TX_P_DATA (SEND_LO: result[7:0]; SEND_HI: result[15:8]) with TX_D_VLD=1.
  - Hold data and TX_D_VLD until TX_BUSY=1 is sampled, then deassert TX_D_VLD.
  - The next byte waits for TX_BUSY to return to 0.
  - TX_D_VLD and TX_BUSY high in the same cycle counts as acceptance.
- SEND_LO exit:
  - Go to SEND_HI when OUT_WIDTH=16 and no timeout occurred.
  - Otherwise return to IDLE once the byte is accepted.
- SEND_HI: return to IDLE once the byte is accepted.
- RX bytes arriving in any state after GET_FUN and before IDLE are dropped; there is no queue.
- Stored A and B persist across frames; only CMD_OPER updates them.
- ALU_FUN codes with no defined ALU operation are passed through unchanged; the ALU returns 0 for them, and that 0 is transmitted normally.

Test Plan:
- Reset with TX_BUSY=0 -> all outputs 0, CTRL_BUSY=0; send 0xCC,0x05,0x03,0x00 with ALU model -> ALU_A=5, ALU_B=3, FUN=0; CLK_GATE_EN leads ALU_EN by 1 cycle; TX_P_DATA=0x08 sent once.
- After the previous frame, send 0xDD,0x02 -> ALU_EN with A=5, B=3, FUN=2; TX byte 0x0F; A and B unchanged.
- Send bytes 0x11,0xCC,0x0A,0x0A,0x0A -> 0x11 dropped; FUN=0xA (compare); TX 0x01; upper FUN nibble of 0x0A ignored.
- ALU model never raises ALU_OUT_VALID -> after RES_TIMEOUT cycles TX sends exactly one 0xEE; CLK_GATE_EN drops; returns to IDLE.
- OUT_WIDTH=16, A=0xFF, B=0xFF, FUN=2; TX_BUSY held high for 20 cycles before the first byte -> TX_D_VLD not asserted until TX_BUSY=0; bytes 0x01 then 0xFE in order.
- Assert RST low during SEND_LO with TX_D_VLD=1 -> TX_D_VLD, CLK_GATE_EN, CTRL_BUSY drop asynchronously; after release, no byte sent without a new frame.
